// File: rtl/menu_ctrl_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : menu_pkg
//  Description : Shared key codes, controller state encoding and CLOG2 helper
//                for the parametrised menu controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package menu_pkg;

  localparam logic [7:0] KEY_ESC   = 8'h1B;
  localparam logic [7:0] KEY_ENTER = 8'h0D;
  localparam logic [7:0] KEY_W     = 8'h77;
  localparam logic [7:0] KEY_A     = 8'h61;
  localparam logic [7:0] KEY_S     = 8'h73;
  localparam logic [7:0] KEY_D     = 8'h64;
  localparam logic [7:0] KEY_0     = 8'h30;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_MENU = 1'b1
  } state_e;

  // Ceiling log2 with a floor of 1 so a cursor always has at least one bit.
  function automatic int CLOG2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/menu_ctrl_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : menu_ctrl_param_if
//  Description : VGA pixel bus (counters, syncs, colour) between pipeline
//                stages.
//  Revision    : 1.0 - initial release
// ============================================================================
interface menu_ctrl_param_if;
  logic [15:0] hcount;
  logic [15:0] vcount;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, rgb);
endinterface
`default_nettype wire

// File: rtl/menu_ctrl_param_overlay_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : menu_overlay_pipe
//  Description : Two-stage video pipeline; stage 1 classifies the pixel
//                against the menu panel and cursor row, stage 2 composites.
//  Revision    : 1.0 - initial release
// ============================================================================
module menu_overlay_pipe
  import menu_pkg::*;
#(
  parameter int          NUM_ITEMS    = 4,
  parameter int          MENU_X       = 448,
  parameter int          MENU_Y       = 256,
  parameter int          MENU_W       = 128,
  parameter int          ROW_H        = 16,
  parameter logic [11:0] BG_COLOR     = 12'h333,
  parameter logic [11:0] HILITE_COLOR = 12'h555
) (
  input  wire logic                           clk,
  input  wire logic                           rst,
  input  wire logic                           menu_active,
  input  wire logic [CLOG2(NUM_ITEMS)-1:0]    cursor,
  menu_ctrl_param_if.slave                    vin,
  menu_ctrl_param_if.master                   vout
);

  localparam int CW = CLOG2(NUM_ITEMS);

  logic [31:0]   h_ext, v_ext;
  logic          in_panel;
  logic [CW-1:0] row;

  logic [15:0] s1_h_q, s1_h_d, s1_v_q, s1_v_d, s2_h_q, s2_h_d, s2_v_q, s2_v_d;
  logic        s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d;
  logic [11:0] s1_rgb_q, s1_rgb_d, s2_rgb_q, s2_rgb_d;
  logic        s1_paint_q, s1_paint_d, s1_hit_q, s1_hit_d;

  assign h_ext = {16'd0, vin.hcount};
  assign v_ext = {16'd0, vin.vcount};

  // Panel bounds and row index; the row comes from a ladder of row-boundary
  // compares so no divider is needed.
  always_comb begin
    in_panel = (h_ext >= 32'(MENU_X)) && (h_ext < 32'(MENU_X + MENU_W)) &&
               (v_ext >= 32'(MENU_Y)) && (v_ext < 32'(MENU_Y + NUM_ITEMS * ROW_H));
    row = '0;
    for (int i = 1; i < NUM_ITEMS; i++) begin
      if (v_ext >= 32'(MENU_Y + i * ROW_H)) row = i[CW-1:0];
    end
  end

  // Next values for both stages; menu state is captured alongside the pixel.
  always_comb begin
    s1_h_d     = vin.hcount;
    s1_v_d     = vin.vcount;
    s1_hs_d    = vin.hsync;
    s1_vs_d    = vin.vsync;
    s1_rgb_d   = vin.rgb;
    s1_paint_d = menu_active && in_panel;
    s1_hit_d   = (row == cursor);
    s2_h_d     = s1_h_q;
    s2_v_d     = s1_v_q;
    s2_hs_d    = s1_hs_q;
    s2_vs_d    = s1_vs_q;
    s2_rgb_d   = s1_rgb_q;
    if (s1_paint_q) s2_rgb_d = s1_hit_q ? HILITE_COLOR : BG_COLOR;
  end

  // Pipeline registers; reset blanks both stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_h_q <= '0; s1_v_q <= '0; s1_hs_q <= 1'b0; s1_vs_q <= 1'b0; s1_rgb_q <= '0;
      s1_paint_q <= 1'b0; s1_hit_q <= 1'b0;
      s2_h_q <= '0; s2_v_q <= '0; s2_hs_q <= 1'b0; s2_vs_q <= 1'b0; s2_rgb_q <= '0;
    end else begin
      s1_h_q <= s1_h_d; s1_v_q <= s1_v_d; s1_hs_q <= s1_hs_d; s1_vs_q <= s1_vs_d;
      s1_rgb_q <= s1_rgb_d; s1_paint_q <= s1_paint_d; s1_hit_q <= s1_hit_d;
      s2_h_q <= s2_h_d; s2_v_q <= s2_v_d; s2_hs_q <= s2_hs_d; s2_vs_q <= s2_vs_d;
      s2_rgb_q <= s2_rgb_d;
    end
  end

  assign vout.hcount = s2_h_q;
  assign vout.vcount = s2_v_q;
  assign vout.hsync  = s2_hs_q;
  assign vout.vsync  = s2_vs_q;
  assign vout.rgb    = s2_rgb_q;

endmodule
`default_nettype wire

// File: rtl/menu_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module      : menu_ctrl_param
//  Description : Parametrised settings menu: key FSM with hold-off, cursor,
//                adjustable value bank and video overlay.
//  Revision    : 1.0 - initial release
// ============================================================================
module menu_ctrl_param
  import menu_pkg::*;
#(
  parameter int                         NUM_ITEMS    = 4,
  parameter int                         VAL_W        = 4,
  // Item 0 in the LSBs: item1 = F, all others 0.
  parameter logic [NUM_ITEMS*VAL_W-1:0] INIT_VALUES  = 16'h00F0,
  parameter int                         WRAP         = 1,
  parameter int                         HOLDOFF      = 4,
  parameter int                         MENU_X       = 448,
  parameter int                         MENU_Y       = 256,
  parameter int                         MENU_W       = 128,
  parameter int                         ROW_H        = 16,
  parameter logic [11:0]                BG_COLOR     = 12'h333,
  parameter logic [11:0]                HILITE_COLOR = 12'h555
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  input  wire logic [7:0]                    key,
  menu_ctrl_param_if.slave                   vid_in,
  menu_ctrl_param_if.master                  vid_out,
  output logic                               menu_active,
  output logic                               game_start,
  output logic [CLOG2(NUM_ITEMS)-1:0]        cursor,
  output logic [NUM_ITEMS*VAL_W-1:0]         values
);

  localparam int CW = CLOG2(NUM_ITEMS);

  state_e                     state_q, state_d;
  logic                       game_start_q, game_start_d;
  logic [CW-1:0]              cursor_q, cursor_d;
  logic [NUM_ITEMS*VAL_W-1:0] values_q, values_d;
  logic [7:0]                 hold_q, hold_d;
  logic                       accept;
  int                         sel;
  int                         key_int;

  // One step up or down, wrapping or clamping at the value range ends.
  function automatic logic [VAL_W-1:0] bump(input logic [VAL_W-1:0] v, input logic up);
    if (up) begin
      if (WRAP == 0 && (&v)) return v;
      return v + 1'b1;
    end
    if (WRAP == 0 && v == '0) return v;
    return v - 1'b1;
  endfunction

  // Key decode, hold-off and next state for cursor, values and flags.
  always_comb begin
    state_d      = state_q;
    game_start_d = game_start_q;
    cursor_d     = cursor_q;
    values_d     = values_q;
    hold_d       = (hold_q != 8'd0) ? hold_q - 8'd1 : hold_q;
    accept       = (key != 8'd0) && (hold_q == 8'd0);
    sel          = int'(cursor_q);
    key_int      = int'({24'd0, key});
    if (accept) begin
      hold_d = 8'(HOLDOFF);
      if (state_q == ST_RUN) begin
        if (key == KEY_ESC)        state_d      = ST_MENU;
        else if (key == KEY_ENTER) game_start_d = 1'b1;
      end else begin
        case (key)
          KEY_ESC: state_d  = ST_RUN;
          KEY_W:   cursor_d = (cursor_q == '0) ? CW'(NUM_ITEMS - 1) : cursor_q - 1'b1;
          KEY_S:   cursor_d = (cursor_q == CW'(NUM_ITEMS - 1)) ? '0 : cursor_q + 1'b1;
          KEY_D:   values_d[sel*VAL_W +: VAL_W] = bump(values_q[sel*VAL_W +: VAL_W], 1'b1);
          KEY_A:   values_d[sel*VAL_W +: VAL_W] = bump(values_q[sel*VAL_W +: VAL_W], 1'b0);
          default: begin
            // Legacy direct keys '1'..N bump the matching item.
            if (key_int > int'(KEY_0) && key_int <= int'(KEY_0) + NUM_ITEMS) begin
              sel = key_int - int'(KEY_0) - 1;
              values_d[sel*VAL_W +: VAL_W] = bump(values_q[sel*VAL_W +: VAL_W], 1'b1);
            end
          end
        endcase
      end
    end
  end

  // Control registers; reset wins over any key in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      game_start_q <= 1'b0;
      cursor_q     <= '0;
      values_q     <= INIT_VALUES;
      hold_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      game_start_q <= game_start_d;
      cursor_q     <= cursor_d;
      values_q     <= values_d;
      hold_q       <= hold_d;
    end
  end

  assign menu_active = (state_q == ST_MENU);
  assign game_start  = game_start_q;
  assign cursor      = cursor_q;
  assign values      = values_q;

  menu_overlay_pipe #(
    .NUM_ITEMS    (NUM_ITEMS),
    .MENU_X       (MENU_X),
    .MENU_Y       (MENU_Y),
    .MENU_W       (MENU_W),
    .ROW_H        (ROW_H),
    .BG_COLOR     (BG_COLOR),
    .HILITE_COLOR (HILITE_COLOR)
  ) u_overlay (
    .clk         (clk),
    .rst         (rst),
    .menu_active (menu_active),
    .cursor      (cursor_q),
    .vin         (vid_in),
    .vout        (vid_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_menu_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_menu_ctrl_param
//  Description : Scoreboard bench for menu_ctrl_param; one wrapping and one
//                saturating instance share stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_menu_ctrl_param;
  import menu_pkg::*;

  localparam int N  = 4;
  localparam int VW = 4;
  localparam int HO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key = 8'd0;

  menu_ctrl_param_if vin ();
  menu_ctrl_param_if vo_w ();
  menu_ctrl_param_if vo_s ();

  logic        ma_w, gs_w, ma_s, gs_s;
  logic [1:0]  cur_w, cur_s;
  logic [15:0] val_w, val_s;

  menu_ctrl_param #(.NUM_ITEMS(N), .VAL_W(VW), .INIT_VALUES(16'h00F0), .WRAP(1), .HOLDOFF(HO))
  u_dut (.clk(clk), .rst(rst), .key(key), .vid_in(vin), .vid_out(vo_w),
         .menu_active(ma_w), .game_start(gs_w), .cursor(cur_w), .values(val_w));

  menu_ctrl_param #(.NUM_ITEMS(N), .VAL_W(VW), .INIT_VALUES(16'h00F0), .WRAP(0), .HOLDOFF(HO))
  u_sat (.clk(clk), .rst(rst), .key(key), .vid_in(vin), .vid_out(vo_s),
         .menu_active(ma_s), .game_start(gs_s), .cursor(cur_s), .values(val_s));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] h, v;
    logic        hs, vs;
    logic [11:0] rgb;
  } pix_t;

  typedef struct {
    logic        ma, gs;
    logic [1:0]  cur;
    logic [15:0] vw, vs;
    pix_t        px;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit   m_menu, m_gs;
  int   m_cur, m_hold;
  int   m_vw[N], m_vs[N];
  pix_t m_s1, m_s2;

  // Pixel source
  bit          px_rand = 1'b0;
  logic [15:0] px_h = 16'd500, px_v = 16'd260;
  logic [11:0] px_rgb = 12'hABC;

  function automatic int adj(int v, int d, bit wrap);
    int mx = (1 << VW) - 1;
    int r = v + d;
    if (wrap) return r & mx;
    if (r < 0) return 0;
    if (r > mx) return mx;
    return r;
  endfunction

  function automatic logic [15:0] pack(input int a[N]);
    logic [15:0] p = '0;
    for (int i = 0; i < N; i++) p[i*VW +: VW] = 4'(a[i]);
    return p;
  endfunction

  // Advance the model by one clock edge and queue what the DUT must show.
  task automatic model_edge();
    pix_t p;
    int   hh, vv, idx;
    bit   inp;
    exp_t e;
    if (rst) begin
      m_s1 = '{h:0, v:0, hs:0, vs:0, rgb:0};
      m_s2 = m_s1;
      m_menu = 0; m_gs = 0; m_cur = 0; m_hold = 0;
      m_vw = '{0, 15, 0, 0};
      m_vs = '{0, 15, 0, 0};
    end else begin
      m_s2 = m_s1;
      hh = int'(vin.hcount); vv = int'(vin.vcount);
      inp = (hh >= 448) && (hh < 448 + 128) && (vv >= 256) && (vv < 256 + N * 16);
      p.h = vin.hcount; p.v = vin.vcount; p.hs = vin.hsync; p.vs = vin.vsync;
      p.rgb = vin.rgb;
      if (m_menu && inp) p.rgb = (((vv - 256) / 16) == m_cur) ? 12'h555 : 12'h333;
      m_s1 = p;
      if (key != 8'd0 && m_hold == 0) begin
        m_hold = HO;
        if (!m_menu) begin
          if (key == 8'h1B) m_menu = 1;
          else if (key == 8'h0D) m_gs = 1;
        end else begin
          idx = -1;
          if (key == 8'h1B) m_menu = 0;
          else if (key == "w") m_cur = (m_cur + N - 1) % N;
          else if (key == "s") m_cur = (m_cur + 1) % N;
          else if (key == "d") begin
            m_vw[m_cur] = adj(m_vw[m_cur], 1, 1); m_vs[m_cur] = adj(m_vs[m_cur], 1, 0);
          end else if (key == "a") begin
            m_vw[m_cur] = adj(m_vw[m_cur], -1, 1); m_vs[m_cur] = adj(m_vs[m_cur], -1, 0);
          end else if (int'(key) >= 49 && int'(key) <= 48 + N) idx = int'(key) - 49;
          if (idx >= 0) begin
            m_vw[idx] = adj(m_vw[idx], 1, 1); m_vs[idx] = adj(m_vs[idx], 1, 0);
          end
        end
      end else if (m_hold > 0) begin
        m_hold--;
      end
    end
    e.ma = m_menu; e.gs = m_gs; e.cur = 2'(m_cur);
    e.vw = pack(m_vw); e.vs = pack(m_vs); e.px = m_s2;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs (before the edge), model it, wait to next negedge.
  task automatic cyc(input logic [7:0] k, input logic r);
    key = k;
    rst = r;
    if (px_rand) begin
      px_h = 16'($urandom_range(420, 600));
      px_v = 16'($urandom_range(230, 340));
      px_rgb = 12'($urandom);
    end
    vin.hcount = px_h;
    vin.vcount = px_v;
    vin.hsync  = px_rand ? 1'($urandom) : 1'b0;
    vin.vsync  = px_rand ? 1'($urandom) : 1'b1;
    vin.rgb    = px_rgb;
    model_edge();
    @(negedge clk);
  endtask

  task automatic press(input logic [7:0] k, input int n);
    for (int i = 0; i < n; i++) cyc(k, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs present every cycle, compare against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("menu_active", {15'd0, ma_w}, {15'd0, e.ma});
        chk("game_start", {15'd0, gs_w}, {15'd0, e.gs});
        chk("cursor", {14'd0, cur_w}, {14'd0, e.cur});
        chk("values_wrap", val_w, e.vw);
        chk("values_sat", val_s, e.vs);
        chk("sat_menu_active", {15'd0, ma_s}, {15'd0, e.ma});
        chk("sat_cursor", {14'd0, cur_s}, {14'd0, e.cur});
        chk("sat_game_start", {15'd0, gs_s}, {15'd0, e.gs});
        chk("hcount_out", vo_w.hcount, e.px.h);
        chk("vcount_out", vo_w.vcount, e.px.v);
        chk("hsync_out", {15'd0, vo_w.hsync}, {15'd0, e.px.hs});
        chk("vsync_out", {15'd0, vo_w.vsync}, {15'd0, e.px.vs});
        chk("rgb_out", {4'd0, vo_w.rgb}, {4'd0, e.px.rgb});
        chk("sat_rgb_out", {4'd0, vo_s.rgb}, {4'd0, e.px.rgb});
      end
    end
  end

  logic [7:0] keytab [14];

  initial begin
    keytab = '{8'h00, 8'h1B, 8'h0D, 8'h77, 8'h61, 8'h73, 8'h64,
               8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h39, 8'hFF};
    // Reset, then pass-through pixel (500,260)
    cyc(8'd0, 1'b1);
    cyc(8'd0, 1'b1);
    press(8'd0, 4);
    // Enter menu and walk cursor down twice with a held 's'
    press(8'h1B, 1);
    press("s", 10);
    press(8'd0, 6);
    px_h = 16'd450; px_v = 16'd290; press(8'd0, 3);
    px_h = 16'd450; px_v = 16'd260; press(8'd0, 3);
    // Cursor to item 1; 'd' wraps F->0 (saturating copy holds F)
    press("w", 1); press(8'd0, 5);
    press("d", 1); press(8'd0, 5);
    // Cursor to item 0; 'a' wraps 0->F (saturating copy holds 0)
    press("w", 1); press(8'd0, 5);
    press("a", 1); press(8'd0, 5);
    // Direct digit, then an out-of-range digit swallowing the following 'd'
    press("3", 1); press(8'd0, 5);
    press("9", 1); press("d", 1); press(8'd0, 5);
    // Back to RUN, start the game, toggle the menu around it
    press(8'h1B, 1); press(8'd0, 5);
    press(8'h0D, 1); press(8'd0, 5);
    press(8'h1B, 1); press(8'd0, 5);
    press(8'h0D, 1); press(8'd0, 5);
    press(8'h1B, 1); press(8'd0, 5);
    // Reset coinciding with a 'd' while in MENU
    press(8'h1B, 1); press(8'd0, 5);
    cyc("d", 1'b1);
    press(8'd0, 4);
    // Randomised phase
    px_rand = 1'b1;
    for (int n = 0; n < 600; n++) begin
      press(keytab[$urandom_range(0, 13)], int'($urandom_range(1, 8)));
      if ($urandom_range(0, 99) == 0) cyc(8'd0, 1'b1);
    end
    press(8'd0, 3);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() > 1) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected at most 1", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
